// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module   : if_fetch_unit_if
// Purpose  : Redirect, stall, instruction-memory and IF/ID signals of the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Owns the architectural PC. It issues one imem read at a time and
//            flushes wrong-path fetches on a redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    if_fetch_unit_if.master bus
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic        w_accept;
    logic        w_rsp;

    // A new request is allowed only when the output register is empty or drains this cycle.
    assign bus.imem_req  = !rst && (state_q == ST_FETCH) && (!if_valid_q || !bus.stall);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

    assign w_accept = bus.imem_req && bus.imem_gnt;
    assign w_rsp    = (state_q == ST_WAIT) && bus.imem_rvalid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        if (if_valid_q && !bus.stall) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_FETCH: begin
                if (w_accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end
            end
            default: begin
                if (w_rsp) begin
                    state_d   = ST_FETCH;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = bus.imem_rdata;
                    end
                end
            end
        endcase

        // Redirect wins over everything: flush the output and mark the one in-flight response stale.
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc & ~32'h3;
            if_valid_d = 1'b0;
            if ((state_q == ST_WAIT) && !bus.imem_rvalid) begin
                discard_d = 1'b1;
            end
            if ((state_q == ST_FETCH) && w_accept) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'd0;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Scoreboard bench for if_fetch_unit with a behavioural imem responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'hBFC00000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    // Reference model of the fetch unit as seen from outside
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_wrong;
    logic [31:0] m_out_addr;
    int          m_cnt;
    int          lat;
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_iinstr;
    bit          stray_rv;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == C_RESET_PC) ? 32'h24080001 : ((a ^ 32'hA5A50000) + 32'h13);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a negedge with the caller's inputs applied.
    task automatic tick();
        bit          g;
        bit          rv;
        bit          redir;
        bit          deliver;
        bit          exp_req;
        logic [31:0] rp;
        exp_t        e;

        rv = m_out && (m_cnt == 0);
        bus.imem_rvalid = rv || stray_rv;
        bus.imem_rdata  = rv ? mem_word(m_out_addr) : (stray_rv ? 32'h0BAD0BAD : 32'hDEADBEEF);
        #1;
        exp_req = !m_out && (!m_v || !bus.stall);
        check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (bus.imem_req) check_eq("imem_addr", bus.imem_addr, m_pc);

        g       = bus.imem_req && bus.imem_gnt;
        redir   = bus.redirect_valid;
        rp      = bus.redirect_pc;
        deliver = 1'b0;

        if (rv) begin
            deliver = !m_wrong && !redir;
            if (deliver) sb.push_back('{pc: m_out_addr, instr: mem_word(m_out_addr)});
            m_out   = 1'b0;
            m_wrong = 1'b0;
        end else if (m_out) begin
            if (redir) m_wrong = 1'b1;
            if (m_cnt > 0) m_cnt--;
        end
        if (m_v && !bus.stall) m_v = 1'b0;
        if (deliver) begin
            m_v      = 1'b1;
            m_ipc    = m_out_addr;
            m_iinstr = mem_word(m_out_addr);
        end
        if (redir) m_v = 1'b0;
        if (g) begin
            m_out      = 1'b1;
            m_out_addr = m_pc;
            m_wrong    = redir;
            m_cnt      = lat - 1;
        end
        if (redir) m_pc = rp & ~32'h3;
        else if (g) m_pc = m_pc + 32'd4;

        @(posedge clk);
        #1;
        if (deliver && sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("sb_valid", {31'd0, bus.if_valid}, 32'd1);
            check_eq("sb_pc", bus.if_pc, e.pc);
            check_eq("sb_instr", bus.if_instr, e.instr);
        end
        check_eq("if_valid", {31'd0, bus.if_valid}, {31'd0, m_v});
        if (m_v) begin
            check_eq("if_pc_hold", bus.if_pc, m_ipc);
            check_eq("if_instr_hold", bus.if_instr, m_iinstr);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        stray_rv           = 1'b0;
    endtask

    task automatic run_to_valid(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 60 && !bus.if_valid; i++) tick();
        check_eq({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd1);
        check_eq({tag, "_pc"}, bus.if_pc, exp_pc);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
    endtask

    task automatic model_reset();
        m_pc    = C_RESET_PC;
        m_out   = 1'b0;
        m_wrong = 1'b0;
        m_cnt   = 0;
        m_v     = 1'b0;
        sb.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        lat   = 1;
        stray_rv = 1'b0;
        m_ipc    = 32'd0;
        m_iinstr = 32'd0;
        m_out_addr = 32'd0;
        model_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.stall          = 1'b0;
        bus.imem_gnt       = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'd0;

        @(negedge clk);
        check_eq("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check_eq("rst_if_pc", bus.if_pc, 32'd0);
        check_eq("rst_if_instr", bus.if_instr, 32'd0);
        check_eq("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back fetches, 1-cycle memory
        run_to_valid("boot", C_RESET_PC);
        check_eq("boot_instr", bus.if_instr, 32'h24080001);
        for (int i = 0; i < 6; i++) tick();

        // Hold under stall, then release
        lat = 2;
        bus.stall = 1'b1;
        run_to_valid("stall_fill", m_pc - 32'd4);
        for (int i = 0; i < 5; i++) tick();
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Redirect while waiting for a response
        for (int i = 0; i < 20 && !(m_out && m_cnt > 0); i++) tick();
        redirect(32'h80001002);
        run_to_valid("redir_wait", 32'h80001000);

        // Redirect in the grant cycle
        lat = 1;
        for (int i = 0; i < 20 && m_out; i++) tick();
        redirect(32'h80002000);
        run_to_valid("redir_gnt", 32'h80002000);

        // Redirect in the response cycle
        for (int i = 0; i < 20 && !(m_out && m_cnt == 0); i++) tick();
        redirect(32'h80003000);
        run_to_valid("redir_rsp", 32'h80003000);

        // Redirect while stalled with a valid instruction
        bus.stall = 1'b1;
        tick();
        run_to_valid("stall_pre", m_ipc);
        tick();
        redirect(32'h80004000);
        check_eq("redir_stall_flush", {31'd0, bus.if_valid}, 32'd0);
        bus.stall = 1'b0;
        run_to_valid("redir_stall", 32'h80004000);

        // Two redirects while one request is in flight
        lat = 4;
        for (int i = 0; i < 20 && !(m_out && m_cnt > 1); i++) tick();
        redirect(32'h80005000);
        redirect(32'h80006004);
        run_to_valid("double_redir", 32'h80006004);

        // PC wrap
        lat = 1;
        redirect(32'hFFFFFFFD);
        run_to_valid("wrap_top", 32'hFFFFFFFC);
        tick();
        run_to_valid("wrap_zero", 32'h00000000);

        // Async reset in WAIT, then a late response that must be ignored
        lat = 3;
        for (int i = 0; i < 20 && !m_out; i++) tick();
        rst = 1'b1;
        #1;
        check_eq("rst2_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check_eq("rst2_if_pc", bus.if_pc, 32'd0);
        check_eq("rst2_if_instr", bus.if_instr, 32'd0);
        check_eq("rst2_imem_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.imem_gnt = 1'b0;
        stray_rv     = 1'b1;
        tick();
        bus.imem_gnt = 1'b1;
        lat = 1;
        run_to_valid("restart", C_RESET_PC);
        check_eq("restart_instr", bus.if_instr, 32'h24080001);
        for (int i = 0; i < 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-side consumer of the next-PC value; owns the architectural PC register of the pipelined core.
- Issues one instruction-memory read at a time and delivers {pc, instr} to the IF/ID boundary with valid/stall flow control.
- Accepts taken-branch/jump redirects from the execute stage and flushes wrong-path fetches, including in-flight ones.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset (boot vector).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  one-cycle pulse: taken branch/jump resolved
redirect_pc  input  32  target PC accompanying redirect_valid
stall  input  1  ID cannot accept; hold if_* outputs
imem_req  output  1  read request valid
imem_addr  output  32  read address, word aligned
imem_gnt  input  1  memory accepts request this cycle (imem_req & imem_gnt)
imem_rvalid  input  1  read data valid, in order, >=1 cycle after grant
imem_rdata  input  32  instruction word
if_valid  output  1  if_pc/if_instr hold a valid instruction
if_pc  output  32  address of delivered instruction
if_instr  output  32  delivered instruction word

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=FETCH, discard=0.
  - if_valid=0, if_pc=0, if_instr=0, imem_req=0.
- imem_addr = pc in FETCH; it is a don't-care elsewhere but is driven as pc.
- States:
  - FETCH: imem_req=1 iff (!if_valid | !stall), i.e. the output register is empty or drains this cycle.
    - On grant: req_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), go to WAIT.
  - WAIT: imem_req=0.
    - On imem_rvalid with discard=0: if_valid<=1, if_pc<=req_pc, if_instr<=imem_rdata; go to FETCH.
    - On imem_rvalid with discard=1: drop the data, clear discard, go to FETCH.
- At most one request outstanding. The output register is guaranteed free when the response arrives, so no skid buffer is needed.
- Output register:
  - Cleared (if_valid<=0) when if_valid & !stall and no new response is loaded in the same cycle.
  - With stall=1, if_valid/if_pc/if_instr are held stable.
- Latency: grant at cycle N, rvalid at N+k gives if_valid=1 at N+k+1. Best-case throughput is one instruction every 2 cycles (k=1).
- Redirect (highest priority, overrides stall and normal pc update):
  - pc<=redirect_pc with bits[1:0] forced to 00.
  - if_valid<=0 (wrong-path instruction flushed, even if stalled).
  - In WAIT without rvalid this cycle: discard<=1, stay in WAIT.
  - In WAIT with rvalid this cycle: data dropped, go to FETCH, discard stays 0.
  - In FETCH with grant this cycle: the request proceeds, discard<=1, go to WAIT; pc takes redirect_pc, not pc+4.
  - In FETCH without grant: stay in FETCH; the next request uses the new pc.
- Redirect while discard is already 1: pc is updated again and discard stays 1 (still exactly one response to drop).
- imem_req is never raised during rst or in the cycle a redirect is sampled in WAIT.
- stall has no effect on an in-flight request; it only gates new requests and output clearing.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle rvalid returning 32'h24080001 → first imem_addr=BFC00000; if_valid=1, if_pc=BFC00000, if_instr=24080001 two cycles after grant; next imem_addr=BFC00004.
- stall=1 for 5 cycles while if_valid=1 → if_* held constant, imem_req=0; stall drops → request to the next pc in that same cycle.
- Redirect to 32'h80001002 while in WAIT; stale rvalid arrives next cycle → stale word never appears on if_*; next imem_addr=80001000; delivered if_pc=80001000.
- Redirect in the same cycle as grant, and separately in the same cycle as rvalid → one response discarded in each case; if_valid stays 0 until the target instruction returns.
- Redirect with stall=1 and if_valid=1 → if_valid=0 next cycle; wrong-path instruction not delivered.
- pc=FFFFFFFC fetched → next imem_addr=00000000; asserting rst mid-WAIT → outputs zero immediately, restart at BFC00000, late rvalid after reset is ignored.
